spi_master_parallel: RTL and testbench
======================================

# spi_master_parallel

Master end of the team's parallel-word SPI link (CPOL=0, CPHA=0): on a start request it asserts chip select, generates one SCLK pulse, drives a full NB_BITS word on the MOSI bus and captures a full word from the MISO bus. It sits on the host/debug side of the MIPS platform, facing the parallel SPI slave, and gives the local logic a start/busy/done handshake. SCLK timing is derived from the system clock by a programmable divider, so the slave's registered edge detector always sees clean, multi-cycle phases.

## Interface
- NB_BITS, 32, width of the MOSI/MISO words and of i_data/o_data
- CLK_DIV, 4, system-clock cycles per SCLK phase (setup, high, hold); legal range ≥ 2
- i_clk  in  1  system clock; all logic on rising edge
- i_rst  in  1  reset; synchronous and active-high
- i_start  in  1  transfer request; sampled only in IDLE
- i_data  in  NB_BITS  word to send; latched on accepted start
- i_MISO  in  NB_BITS  word returned by the slave
- o_MOSI  out  NB_BITS  word driven to the slave; stable for the whole transfer
- o_SCLK  out  1  serial clock, idle low
- o_cs  out  1  chip select, active-high (slave drives MISO only while high)
- o_data  out  NB_BITS  last received word; holds until the next capture
- o_busy  out  1  high from the cycle after an accepted start through DONE
- o_done  out  1  one-cycle pulse when o_data has been updated

## Operation
- All outputs are registered. Reset values: o_MOSI=0, o_SCLK=0, o_cs=0, o_data=0, o_busy=0, o_done=0, state=IDLE, divider counter=0.
- FSM states: IDLE, SETUP, HIGH, HOLD, DONE.
- IDLE: o_cs=0, o_SCLK=0. If i_start=1, latch i_data into o_MOSI, clear counter, go to SETUP.
- SETUP: o_cs=1, o_SCLK=0 for CLK_DIV cycles. This gives the slave time to load its transmit word onto MISO. Then go to HIGH.
- HIGH: o_cs=1, o_SCLK=1 for CLK_DIV cycles. On the last HIGH cycle, register i_MISO into o_data. Then go to HOLD.
- HOLD: o_cs=1, o_SCLK=0 for CLK_DIV cycles. o_MOSI stays stable so the slave's registered falling-edge detector can capture it. Then go to DONE.
- DONE: o_cs=0, o_SCLK=0, o_done=1, o_busy=1 for one cycle, then go to IDLE.
- Divider: counter width clog2(CLK_DIV). It counts 0..CLK_DIV-1, wraps to 0 on every phase change, and is held at 0 in IDLE and DONE.
- i_start outside IDLE (including during DONE) is ignored and is not queued.
- i_data changes after the start is accepted do not affect o_MOSI. i_MISO is sampled only at the single HIGH-end cycle.
- Reset mid-transfer aborts on the next edge. All outputs return to their reset values, o_data is cleared, and o_done does not pulse.

## Timing
- Let the start be sampled at edge 0 and D=CLK_DIV.
- o_cs=1 over cycles 1..3D. o_SCLK=1 over cycles D+1..2D.
- o_data is updated at the edge ending cycle 2D.
- o_done=1 in cycle 3D+1. The next IDLE is cycle 3D+2.
- o_busy=1 over cycles 1..3D+1, i.e. 3D+1 cycles.
- Minimum o_cs low gap between back-to-back transfers is 2 cycles (DONE plus the IDLE cycle that samples start). This guarantees the slave returns to its idle state.
- Rising SCLK is at cycle D+1, falling SCLK at cycle 2D+1. o_MOSI is held D cycles after the falling edge, and D ≥ 2 covers the slave's one-cycle detection lag.

## Test plan
- Basic transfer, D=4, NB_BITS=32: i_data=0xDEADBEEF, i_MISO=0x12345678, pulse start. Required: o_cs high for 12 cycles, SCLK high in cycles 5..8, o_MOSI=0xDEADBEEF throughout, o_done in cycle 13 with o_data=0x12345678.
- MISO sampling window: change i_MISO from 0xAAAA0000 to 0x5555FFFF in cycle 6, then to 0 in cycle 9. Required: o_data=0x5555FFFF.
- Start while busy: pulse i_start at cycles 3 and 13 (DONE) with different i_data. Required: exactly one transfer, o_MOSI unchanged, o_busy low at cycle 14.
- Back-to-back: hold i_start=1 continuously. Required: transfers repeat every 3D+2 cycles, o_cs low exactly 2 cycles between them, one o_done per transfer.
- Reset mid-transfer: assert i_rst in cycle 6 (SCLK high). Required: next cycle o_cs=0, o_SCLK=0, o_data=0, o_busy=0, no o_done; a later start completes normally.
- Loopback with the parallel slave, D=2 and D=4: the slave returns 0xCAFEF00D and the master sends 0x0BADC0DE. Required: master o_data=0xCAFEF00D and slave o_data=0x0BADC0DE after each transfer.

Source files
------------

// File: rtl/spi_master_parallel.sv
// Master end of the parallel-word SPI link (CPOL=0, CPHA=0): one SCLK pulse per
// transfer moves a full NB_BITS word each way, with phases timed by a clock divider.
module spi_master_parallel #(
    parameter int unsigned NB_BITS = 32,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_BITS-1:0] i_data,
    input  logic [NB_BITS-1:0] i_MISO,
    output logic [NB_BITS-1:0] o_MOSI,
    output logic               o_SCLK,
    output logic               o_cs,
    output logic [NB_BITS-1:0] o_data,
    output logic               o_busy,
    output logic               o_done
);

    localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_HIGH,
        ST_HOLD,
        ST_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NB_BITS-1:0] mosi_q, mosi_d;
    logic [NB_BITS-1:0] data_q, data_d;
    logic               sclk_q, sclk_d;
    logic               cs_q, cs_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               phase_end;

    // Next-state, divider and output-register inputs; outputs follow the next state
    // so every pin is a flop and tracks the state it belongs to.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        mosi_d    = mosi_q;
        data_d    = data_q;
        phase_end = (cnt_q == CNT_LAST);

        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                if (i_start) begin
                    mosi_d  = i_data;
                    state_d = ST_SETUP;
                end
            end
            ST_SETUP: begin
                cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) begin
                    state_d = ST_HIGH;
                end
            end
            ST_HIGH: begin
                cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) begin
                    // Single MISO sample point: the last cycle SCLK is high.
                    data_d  = i_MISO;
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                cnt_d = phase_end ? '0 : cnt_q + CNT_W'(1);
                if (phase_end) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
            default: begin
                cnt_d   = '0;
                state_d = ST_IDLE;
            end
        endcase

        cs_d   = (state_d == ST_SETUP) || (state_d == ST_HIGH) || (state_d == ST_HOLD);
        sclk_d = (state_d == ST_HIGH);
        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            mosi_q  <= '0;
            data_q  <= '0;
            sclk_q  <= 1'b0;
            cs_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            mosi_q  <= mosi_d;
            data_q  <= data_d;
            sclk_q  <= sclk_d;
            cs_q    <= cs_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign o_MOSI = mosi_q;
    assign o_SCLK = sclk_q;
    assign o_cs   = cs_q;
    assign o_data = data_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

// File: tb/tb_spi_master_parallel.sv
// Bench for spi_master_parallel: directed transfers on a D=4 master with a done-driven
// scoreboard, plus a D=2 master looped back to a behavioural parallel slave.
module tb_spi_master_parallel;

    localparam int unsigned D  = 4;
    localparam int unsigned D2 = 2;
    localparam int unsigned P  = 3 * D + 2;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] mosi;
    } exp_t;

    logic        clk;
    logic        rst;
    logic        i_start;
    logic [31:0] i_data;
    logic [31:0] miso_drv;
    logic [31:0] i_miso;
    logic [31:0] o_mosi;
    logic        o_sclk;
    logic        o_cs;
    logic [31:0] o_data;
    logic        o_busy;
    logic        o_done;
    logic        loopback;

    logic        start2;
    logic [31:0] data2;
    logic [31:0] miso2;
    logic [31:0] mosi2;
    logic        sclk2;
    logic        cs2;
    logic [31:0] odata2;
    logic        busy2;
    logic        done2;

    logic        slv_sclk_q, slv2_sclk_q;
    logic [31:0] slv_cap, slv2_cap;

    exp_t sb_q[$];
    int   n_checks;
    int   n_fail;

    spi_master_parallel #(.NB_BITS(32), .CLK_DIV(D)) u_dut (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(i_start),
        .i_data (i_data),
        .i_MISO (i_miso),
        .o_MOSI (o_mosi),
        .o_SCLK (o_sclk),
        .o_cs   (o_cs),
        .o_data (o_data),
        .o_busy (o_busy),
        .o_done (o_done)
    );

    spi_master_parallel #(.NB_BITS(32), .CLK_DIV(D2)) u_dut2 (
        .i_clk  (clk),
        .i_rst  (rst),
        .i_start(start2),
        .i_data (data2),
        .i_MISO (miso2),
        .o_MOSI (mosi2),
        .o_SCLK (sclk2),
        .o_cs   (cs2),
        .o_data (odata2),
        .o_busy (busy2),
        .o_done (done2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural parallel slave: drives its word while selected, captures MOSI on a
    // registered falling-SCLK detection.
    assign i_miso = loopback ? (o_cs ? 32'hCAFEF00D : 32'h0) : miso_drv;
    assign miso2  = cs2 ? 32'hCAFEF00D : 32'h0;

    always @(posedge clk) begin
        if (rst) begin
            slv_sclk_q  <= 1'b0;
            slv2_sclk_q <= 1'b0;
            slv_cap     <= 32'h0;
            slv2_cap    <= 32'h0;
        end else begin
            slv_sclk_q  <= o_sclk;
            slv2_sclk_q <= sclk2;
            if (loopback && o_cs && slv_sclk_q && !o_sclk) slv_cap <= o_mosi;
            if (cs2 && slv2_sclk_q && !sclk2) slv2_cap <= mosi2;
        end
    end

    task automatic chk(input string name, input int cyc, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: every done pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst && o_done) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_done", 0, 32'(o_done), 32'h0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                chk("sb_data", 0, o_data, e.data);
                chk("sb_mosi", 0, o_mosi, e.mosi);
            end
        end
    end

    // One transfer with per-cycle timing checks; MISO changes at cycles D+2 and 2D+1,
    // and extra start pulses (p1/p2, 0 = none) must be ignored.
    task automatic do_xfer(input logic [31:0] data, input logic [31:0] m_early,
                           input logic [31:0] m_mid, input logic [31:0] m_late,
                           input logic [31:0] exp_data, input int p1, input int p2);
        exp_t e;
        e.data = exp_data;
        e.mosi = data;
        sb_q.push_back(e);
        i_data   = data;
        i_start  = 1'b1;
        miso_drv = m_early;
        tick();
        for (int k = 1; k <= int'(P); k++) begin
            i_start  = (k == p1) || (k == p2);
            i_data   = ~data;
            miso_drv = (k < int'(D) + 2) ? m_early : (k <= 2 * int'(D)) ? m_mid : m_late;
            chk("cs",   k, 32'(o_cs),   32'(k <= 3 * int'(D)));
            chk("sclk", k, 32'(o_sclk), 32'(k > int'(D) && k <= 2 * int'(D)));
            chk("busy", k, 32'(o_busy), 32'(k <= 3 * int'(D) + 1));
            chk("done", k, 32'(o_done), 32'(k == 3 * int'(D) + 1));
            chk("mosi", k, o_mosi, data);
            if (k == 2 * int'(D) + 1) chk("data_upd", k, o_data, exp_data);
            if (k < int'(P)) tick();
        end
        i_start = 1'b0;
        tick();
        chk("idle_busy", int'(P) + 1, 32'(o_busy), 32'h0);
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        rst      = 1'b1;
        i_start  = 1'b0;
        i_data   = 32'h0;
        miso_drv = 32'h0;
        loopback = 1'b0;
        start2   = 1'b0;
        data2    = 32'h0;
        tick();
        tick();
        chk("rst_cs",   0, 32'(o_cs),   32'h0);
        chk("rst_sclk", 0, 32'(o_sclk), 32'h0);
        chk("rst_busy", 0, 32'(o_busy), 32'h0);
        chk("rst_done", 0, 32'(o_done), 32'h0);
        chk("rst_mosi", 0, o_mosi, 32'h0);
        chk("rst_data", 0, o_data, 32'h0);
        rst = 1'b0;
        tick();

        // Basic transfer.
        do_xfer(32'hDEADBEEF, 32'h12345678, 32'h12345678, 32'h12345678, 32'h12345678, 0, 0);
        // MISO sampling window.
        do_xfer(32'h0F0F1234, 32'hAAAA0000, 32'h5555FFFF, 32'h00000000, 32'h5555FFFF, 0, 0);
        // Start while busy and during DONE.
        do_xfer(32'h11223344, 32'h99887766, 32'h99887766, 32'h99887766, 32'h99887766,
                3, 3 * int'(D) + 1);

        // Back-to-back with start held high: three transfers, 2-cycle cs gaps.
        begin
            exp_t e;
            e.data = 32'h89ABCDEF;
            e.mosi = 32'h00C0FFEE;
            for (int n = 0; n < 3; n++) sb_q.push_back(e);
            i_data   = 32'h00C0FFEE;
            miso_drv = 32'h89ABCDEF;
            i_start  = 1'b1;
            tick();
            for (int k = 1; k <= 3 * int'(P); k++) begin
                int p;
                p = (k - 1) % int'(P);
                if (k == 3 * int'(P)) i_start = 1'b0;
                chk("b2b_cs",   k, 32'(o_cs),   32'(p < 3 * int'(D)));
                chk("b2b_sclk", k, 32'(o_sclk), 32'(p >= int'(D) && p < 2 * int'(D)));
                chk("b2b_done", k, 32'(o_done), 32'(p == 3 * int'(D)));
                if (k < 3 * int'(P)) tick();
            end
            tick();
            chk("b2b_idle", 0, 32'(o_busy), 32'h0);
        end

        // Reset while SCLK is high: abort with no done pulse.
        i_data   = 32'h13579BDF;
        miso_drv = 32'h2468ACE0;
        i_start  = 1'b1;
        tick();
        i_start = 1'b0;
        for (int k = 1; k < 6; k++) tick();
        chk("pre_rst_sclk", 6, 32'(o_sclk), 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_cs",   7, 32'(o_cs),   32'h0);
        chk("abort_sclk", 7, 32'(o_sclk), 32'h0);
        chk("abort_data", 7, o_data, 32'h0);
        chk("abort_busy", 7, 32'(o_busy), 32'h0);
        chk("abort_done", 7, 32'(o_done), 32'h0);
        chk("abort_mosi", 7, o_mosi, 32'h0);
        tick();
        do_xfer(32'hA5A5C3C3, 32'h3C3C5A5A, 32'h3C3C5A5A, 32'h3C3C5A5A, 32'h3C3C5A5A, 0, 0);

        // Loopback, D=4.
        loopback = 1'b1;
        do_xfer(32'h0BADC0DE, 32'h0, 32'h0, 32'h0, 32'hCAFEF00D, 0, 0);
        chk("lb4_slave", 0, slv_cap, 32'h0BADC0DE);
        loopback = 1'b0;

        // Loopback, D=2: done expected in cycle 3*D2+1.
        data2  = 32'h0BADC0DE;
        start2 = 1'b1;
        tick();
        start2 = 1'b0;
        data2  = 32'h0;
        begin
            int k;
            k = 1;
            while (!done2 && k < 40) begin
                tick();
                k++;
            end
            chk("lb2_timeout", k, 32'(done2), 32'h1);
            chk("lb2_cycle",   k, 32'(k), 32'(3 * D2 + 1));
            chk("lb2_master",  k, odata2, 32'hCAFEF00D);
            chk("lb2_slave",   k, slv2_cap, 32'h0BADC0DE);
        end
        tick();
        chk("lb2_idle", 0, 32'(busy2), 32'h0);

        begin
            int w;
            w = 0;
            while (sb_q.size() != 0 && w < 20) begin
                tick();
                w++;
            end
            chk("sb_drain", 0, 32'(sb_q.size()), 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
